ahb_master_bridge: RTL
======================

Name: ahb_master_bridge

Overview:
Converts the multicycle processor's single-outstanding memory request into AHB-Lite master transfers. It drives the address phase and then the data phase, so it sits directly upstream of the address decoder and the on-chip AHB RAM slave. It returns read data, completion and error status to the processor. It handles slave wait states, ERROR responses, misaligned requests and a stuck-bus timeout.

Parameters:
TIMEOUT, 16, consecutive HREADY-low cycles in one phase before the transfer is aborted (range 2..255).

Ports:
HCLK  input  1  bus/system clock, all logic on rising edge
HRESETn  input  1  synchronous active-low reset
cpu_req  input  1  request valid, held stable by the processor until cpu_ready
cpu_we  input  1  1=write, 0=read
cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data, lane-aligned by the processor
cpu_ready  output  1  one-cycle completion pulse
cpu_rdata  output  32  read data, valid while cpu_ready=1
cpu_err  output  1  error flag, valid while cpu_ready=1
HADDR  output  32  AHB address
HTRANS  output  2  00 IDLE, 10 NONSEQ (no other codes are generated)
HWRITE  output  1  AHB write
HSIZE  output  3  {1'b0, effective size}
HWDATA  output  32  AHB write data (data phase)
HRDATA  input  32  AHB read data
HREADY  input  1  transfer ready; tied 1 by zero-wait slaves
HRESP  input  1  0 OKAY, 1 ERROR

Behaviour:
- All outputs are registered.
- Reset (HRESETn=0 at an edge): state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, cpu_ready=0, cpu_rdata=0, cpu_err=0, wait counter=0. Reset mid-transfer abandons it silently, with no cpu_ready.
- States: IDLE, ADDR, DATA, FAULT.
- IDLE:
  - Accept when cpu_req=1 and cpu_ready=0. The ready-pulse cycle never re-accepts the request just completed.
  - On accept, latch we/size/addr/wdata.
- Misalignment check at accept: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned goes to FAULT. No bus transfer, HTRANS stays 00.
  - FAULT always returns to IDLE next cycle with cpu_ready=1, cpu_err=1, cpu_rdata=0.
- Aligned accept goes to ADDR.
- ADDR: HTRANS=10, HADDR/HWRITE/HSIZE from latches.
  - Address phase ends at the first edge with HREADY=1, then go to DATA.
  - In DATA, HTRANS=00, HADDR/HWRITE/HSIZE hold, HWDATA=latched wdata for writes, 0 for reads.
- DATA: ends at the first edge with HREADY=1.
  - On completion: cpu_rdata=HRDATA for reads (0 for writes), cpu_err=HRESP, cpu_ready=1 for one cycle, go to IDLE.
  - HRESP=1 while HREADY=0 is ignored; only the completing cycle counts.
- Zero-wait latency: request sampled at edge 0, ADDR in cycle 1, DATA in cycle 2, cpu_ready high in cycle 3.
  - Each HREADY-low cycle adds exactly one cycle.
- Wait counter:
  - Cleared on every phase transition.
  - Increments each ADDR/DATA cycle with HREADY=0.
  - When the count reaches TIMEOUT, the transfer aborts: HTRANS=00, cpu_ready=1, cpu_err=1, cpu_rdata=0, go to IDLE.
  - The counter saturates and never wraps.
- cpu_err and cpu_rdata are 0 whenever cpu_ready=0.
- Only one transfer is outstanding; there is no pipelined back-to-back NONSEQ.
- Address and data beyond the slave's decoded range pass through unchanged; HADDR[1:0] carries the byte offset.

Test Plan:
- Word write then read, HREADY=1, HRESP=0.
  - Write 0xDEADBEEF to 0x00000010: HTRANS=10 for exactly one cycle with HADDR=0x10, HWRITE=1. HWDATA=0xDEADBEEF in the next cycle. cpu_ready pulses 3 cycles after accept with cpu_err=0.
  - Read of 0x00000010 returns cpu_rdata=0xDEADBEEF.
- Read with HREADY=0 for 2 cycles in the data phase -> cpu_ready at cycle 5. HTRANS=00 throughout DATA. cpu_rdata equals HRDATA sampled on the HREADY=1 edge.
- Read with HRESP=1 on the completing data cycle -> cpu_ready=1, cpu_err=1. The next request is accepted normally.
- TIMEOUT=16, HREADY held 0 from the address phase onward -> abort after 16 wait cycles with cpu_ready=1, cpu_err=1, cpu_rdata=0, HTRANS=00. A following request proceeds once HREADY=1.
- Halfword write to 0x00000001 -> HTRANS never leaves 00. cpu_ready=1, cpu_err=1 two cycles after accept.
- HRESETn=0 during DATA of a write -> next cycle HTRANS=00, all outputs at reset values, no cpu_ready. A new read after release completes normally.

Source files
------------

// File: rtl/ahb_master_bridge.sv
// AHB-Lite master bridge: turns one outstanding processor request into a single
// NONSEQ transfer. Handles wait states, ERROR responses, misalignment and bus timeout.
module ahb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FAULT} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [8:0] TO_LIM    = 9'(TIMEOUT);

  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (sz == 2'b11) ? 2'b10 : sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (eff_size(sz))
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        accept, timeout_hit;
  logic [1:0]  htrans_nxt;
  logic [31:0] haddr_nxt, hwdata_nxt, rdata_nxt;
  logic        hwrite_nxt, ready_nxt, err_nxt;
  logic [2:0]  hsize_nxt;

  // The ready-pulse cycle blocks acceptance so a held request is not taken twice.
  assign accept      = (state == S_IDLE) && cpu_req && !cpu_ready;
  assign timeout_hit = ({1'b0, wcnt} + 9'd1) >= TO_LIM;

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    htrans_nxt = TR_IDLE;
    haddr_nxt  = HADDR;
    hwrite_nxt = HWRITE;
    hsize_nxt  = HSIZE;
    hwdata_nxt = HWDATA;
    ready_nxt  = 1'b0;
    rdata_nxt  = 32'd0;
    err_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          wcnt_nxt = 8'd0;
          if (misaligned(cpu_size, cpu_addr[1:0])) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt  = S_ADDR;
            htrans_nxt = TR_NONSEQ;
            haddr_nxt  = cpu_addr;
            hwrite_nxt = cpu_we;
            hsize_nxt  = {1'b0, eff_size(cpu_size)};
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          state_nxt  = S_DATA;
          wcnt_nxt   = 8'd0;
          hwdata_nxt = we_q ? wdata_q : 32'd0;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = 8'd0;
          ready_nxt = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt   = sat_inc(wcnt);
          htrans_nxt = TR_NONSEQ;
        end
      end
      S_DATA: begin
        // HRESP only matters on the cycle that completes the data phase.
        if (HREADY) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = 8'd0;
          ready_nxt = 1'b1;
          err_nxt   = HRESP;
          rdata_nxt = we_q ? 32'd0 : HRDATA;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = 8'd0;
          ready_nxt = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt = sat_inc(wcnt);
        end
      end
      S_FAULT: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        err_nxt   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      wcnt      <= 8'd0;
      HTRANS    <= TR_IDLE;
      HADDR     <= 32'd0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b010;
      HWDATA    <= 32'd0;
      cpu_ready <= 1'b0;
      cpu_rdata <= 32'd0;
      cpu_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      HTRANS    <= htrans_nxt;
      HADDR     <= haddr_nxt;
      HWRITE    <= hwrite_nxt;
      HSIZE     <= hsize_nxt;
      HWDATA    <= hwdata_nxt;
      cpu_ready <= ready_nxt;
      cpu_rdata <= rdata_nxt;
      cpu_err   <= err_nxt;
    end
  end

  // Request attributes are captured once; the processor may change them after ready.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      we_q    <= cpu_we;
      wdata_q <= cpu_wdata;
    end
  end

endmodule
